// File: rtl/handshake_protocol_monitor.sv
// Passive ready/valid checker for NUM_CH channels: flags stall violations
// (valid drop, payload change, timeout), counts accepted transfers, reports status.
module handshake_protocol_monitor #(
  parameter int NUM_CH     = 3,
  parameter int DATA_WIDTH = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         enable,
  input  logic                         clear_counts,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH-1:0]            ch_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]            err_valid_drop,
  output logic [NUM_CH-1:0]            err_data_change,
  output logic [NUM_CH-1:0]            err_timeout,
  output logic                         any_error,
  output logic [$clog2(NUM_CH):0]      first_err_ch,
  output logic [NUM_CH*CNT_WIDTH-1:0]  xfer_count
);

  localparam int SCW = $clog2(TIMEOUT + 1);
  localparam int FW  = $clog2(NUM_CH) + 1;
  localparam logic [0:0]     ST_IDLE     = 1'b0;
  localparam logic [0:0]     ST_STALL    = 1'b1;
  localparam logic [SCW-1:0] STALL_LIMIT = SCW'(TIMEOUT);
  localparam logic [FW-1:0]  NO_ERR      = '1;

  logic [NUM_CH-1:0] err_vd_d;
  logic [NUM_CH-1:0] err_dc_d;
  logic [NUM_CH-1:0] err_to_d;
  logic [NUM_CH-1:0] ev;
  logic              any_error_q, any_error_d;
  logic [FW-1:0]     first_err_q, first_err_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [0:0]            state_q, state_d;
      logic [SCW-1:0]        stall_cnt_q, stall_cnt_d;
      logic [DATA_WIDTH-1:0] hold_q, hold_d;
      logic [DATA_WIDTH-1:0] data;
      logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
      logic                  vd_q, vd_d, dc_q, dc_d, to_q, to_d;
      logic                  ev_vd, ev_dc, ev_to, cnt_inc;

      assign data = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];

      always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        vd_d        = vd_q;
        dc_d        = dc_q;
        to_d        = to_q;
        ev_vd       = 1'b0;
        ev_dc       = 1'b0;
        ev_to       = 1'b0;
        cnt_inc     = 1'b0;
        if (clear_counts) begin
          state_d     = ST_IDLE;
          stall_cnt_d = '0;
          cnt_d       = '0;
          vd_d        = 1'b0;
          dc_d        = 1'b0;
          to_d        = 1'b0;
        end else if (!enable) begin
          // A stall interrupted by disable is forgotten, not resumed.
          state_d     = ST_IDLE;
          stall_cnt_d = '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (ch_valid[gi] && ch_ready[gi]) begin
                cnt_inc = 1'b1;
              end else if (ch_valid[gi]) begin
                state_d     = ST_STALL;
                hold_d      = data;
                stall_cnt_d = SCW'(1);
              end
            end
            default: begin
              if (!ch_valid[gi]) begin
                ev_vd       = 1'b1;
                state_d     = ST_IDLE;
                stall_cnt_d = '0;
              end else begin
                ev_dc = (data != hold_q);
                if (ch_ready[gi]) begin
                  cnt_inc     = 1'b1;
                  state_d     = ST_IDLE;
                  stall_cnt_d = '0;
                end else if (stall_cnt_q != STALL_LIMIT) begin
                  // Saturating at the limit makes the timeout fire once per episode.
                  stall_cnt_d = stall_cnt_q + SCW'(1);
                  ev_to       = (stall_cnt_d == STALL_LIMIT);
                end
              end
            end
          endcase
          if (cnt_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
          vd_d = vd_q | ev_vd;
          dc_d = dc_q | ev_dc;
          to_d = to_q | ev_to;
        end
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          state_q     <= ST_IDLE;
          stall_cnt_q <= '0;
          hold_q      <= '0;
          cnt_q       <= '0;
          vd_q        <= 1'b0;
          dc_q        <= 1'b0;
          to_q        <= 1'b0;
        end else begin
          state_q     <= state_d;
          stall_cnt_q <= stall_cnt_d;
          hold_q      <= hold_d;
          cnt_q       <= cnt_d;
          vd_q        <= vd_d;
          dc_q        <= dc_d;
          to_q        <= to_d;
        end
      end

      assign err_valid_drop[gi]  = vd_q;
      assign err_data_change[gi] = dc_q;
      assign err_timeout[gi]     = to_q;
      assign err_vd_d[gi]        = vd_d;
      assign err_dc_d[gi]        = dc_d;
      assign err_to_d[gi]        = to_d;
      assign ev[gi]              = ev_vd | ev_dc | ev_to;
      assign xfer_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
  endgenerate

  always_comb begin
    any_error_d = |{err_vd_d, err_dc_d, err_to_d};
    first_err_d = first_err_q;
    if (clear_counts) begin
      first_err_d = NO_ERR;
    end else if (first_err_q == NO_ERR) begin
      // Descending scan so the lowest erroring channel is written last and wins.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (ev[i]) begin
          first_err_d = FW'(i);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      any_error_q <= 1'b0;
      first_err_q <= NO_ERR;
    end else begin
      any_error_q <= any_error_d;
      first_err_q <= first_err_d;
    end
  end

  assign any_error    = any_error_q;
  assign first_err_ch = first_err_q;

endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Bench for handshake_protocol_monitor: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_handshake_protocol_monitor;

  localparam int NCH = 3;
  localparam int DW  = 4;
  localparam int TO  = 16;

  logic        clk = 1'b0;
  logic        RESET, enable, clear_counts;
  logic [2:0]  ch_valid, ch_ready;
  logic [11:0] ch_data;
  logic [2:0]  err_valid_drop, err_data_change, err_timeout;
  logic        any_error;
  logic [2:0]  first_err_ch;
  logic [47:0] xfer_count;
  logic [2:0]  s_vd, s_dc, s_to;
  logic        s_any;
  logic [2:0]  s_first;
  logic [11:0] s_xfer;

  always #5 clk = ~clk;

  handshake_protocol_monitor #(.NUM_CH(NCH), .DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(16)) dut (
    .CLK(clk), .RESET(RESET), .enable(enable), .clear_counts(clear_counts),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
    .err_valid_drop(err_valid_drop), .err_data_change(err_data_change),
    .err_timeout(err_timeout), .any_error(any_error),
    .first_err_ch(first_err_ch), .xfer_count(xfer_count)
  );

  handshake_protocol_monitor #(.NUM_CH(NCH), .DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(4)) dut_sat (
    .CLK(clk), .RESET(RESET), .enable(enable), .clear_counts(clear_counts),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
    .err_valid_drop(s_vd), .err_data_change(s_dc),
    .err_timeout(s_to), .any_error(s_any),
    .first_err_ch(s_first), .xfer_count(s_xfer)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a channel is either mid-stall (with held payload and length) or not.
  int       m_cnt [NCH];
  int       m_cnt4[NCH];
  bit       m_stalled[NCH];
  int       m_len [NCH];
  bit [3:0] m_held[NCH];
  bit [2:0] m_vd, m_dc, m_to;
  int       m_first;

  function automatic void model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_cnt4[c] = 0; m_stalled[c] = 0; m_len[c] = 0;
    end
    m_vd = 0; m_dc = 0; m_to = 0; m_first = -1;
  endfunction

  function automatic void model_step();
    bit [2:0] evt;
    bit       accept;
    evt = 0;
    if (RESET || clear_counts) begin
      model_clear();
    end else if (!enable) begin
      for (int c = 0; c < NCH; c++) begin
        m_stalled[c] = 0; m_len[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        accept = 0;
        if (!m_stalled[c]) begin
          if (ch_valid[c] && ch_ready[c]) accept = 1;
          else if (ch_valid[c]) begin
            m_stalled[c] = 1; m_len[c] = 1; m_held[c] = ch_data[c*DW +: DW];
          end
        end else if (!ch_valid[c]) begin
          m_vd[c] = 1; evt[c] = 1; m_stalled[c] = 0; m_len[c] = 0;
        end else begin
          if (ch_data[c*DW +: DW] != m_held[c]) begin
            m_dc[c] = 1; evt[c] = 1;
          end
          if (ch_ready[c]) begin
            accept = 1; m_stalled[c] = 0; m_len[c] = 0;
          end else if (m_len[c] < TO) begin
            m_len[c]++;
            if (m_len[c] == TO) begin
              m_to[c] = 1; evt[c] = 1;
            end
          end
        end
        if (accept) begin
          if (m_cnt[c] < 65535) m_cnt[c]++;
          if (m_cnt4[c] < 15) m_cnt4[c]++;
        end
      end
      if (m_first < 0) begin
        for (int c = NCH - 1; c >= 0; c--) if (evt[c]) m_first = c;
      end
    end
  endfunction

  function automatic logic [47:0] exp_xfer();
    logic [47:0] r;
    for (int c = 0; c < NCH; c++) r[c*16 +: 16] = 16'(m_cnt[c]);
    return r;
  endfunction

  function automatic logic [11:0] exp_xfer4();
    logic [11:0] r;
    for (int c = 0; c < NCH; c++) r[c*4 +: 4] = 4'(m_cnt4[c]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input int c, input bit v, input bit r, input logic [3:0] d);
    ch_valid[c] = v;
    ch_ready[c] = r;
    ch_data[c*DW +: DW] = d;
  endtask

  task automatic idle_all();
    ch_valid = 0; ch_ready = 0;
  endtask

  task automatic pulse_clear();
    idle_all();
    clear_counts = 1; tick(); clear_counts = 0;
  endtask

  task automatic test_reset();
    RESET = 1; tick(); tick(); RESET = 0;
    n_vec++; if ({err_valid_drop, err_data_change, err_timeout, any_error} !== 10'd0) begin
      n_bad++; $display("FAIL reset_errors got %b exp 0", {err_valid_drop, err_data_change, err_timeout, any_error});
    end
    n_vec++; if (first_err_ch !== 3'b111) begin
      n_bad++; $display("FAIL reset_first got %b exp 111", first_err_ch);
    end
    n_vec++; if (xfer_count !== 48'd0 || s_xfer !== 12'd0) begin
      n_bad++; $display("FAIL reset_counts got %h/%h exp 0", xfer_count, s_xfer);
    end
    $display("test_reset: first_err_ch=%b", first_err_ch);
  endtask

  task automatic test_transfers();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 4'($urandom)); tick();
    end
    idle_all(); tick();
    n_vec++; if (xfer_count !== 48'd5 || s_xfer !== 12'd5) begin
      n_bad++; $display("FAIL xfer_ch0 got %h/%h exp 5", xfer_count, s_xfer);
    end
    n_vec++; if (any_error !== 1'b0 || first_err_ch !== 3'b111) begin
      n_bad++; $display("FAIL xfer_noerr got any=%b first=%b exp 0/111", any_error, first_err_ch);
    end
    $display("test_transfers: xfer_count[0]=%0d", xfer_count[15:0]);
  endtask

  task automatic test_data_change();
    drive(1, 1, 0, 4'hA); tick(); tick();
    drive(1, 1, 0, 4'hB); tick();
    n_vec++; if (err_data_change !== 3'b010 || err_valid_drop !== 3'b000 || err_timeout !== 3'b000) begin
      n_bad++; $display("FAIL data_change got dc=%b vd=%b to=%b exp 010/000/000", err_data_change, err_valid_drop, err_timeout);
    end
    n_vec++; if (first_err_ch !== 3'd1 || any_error !== 1'b1) begin
      n_bad++; $display("FAIL data_change_first got first=%b any=%b exp 001/1", first_err_ch, any_error);
    end
    drive(1, 1, 1, 4'hB); tick();
    idle_all(); tick();
    n_vec++; if (xfer_count[31:16] !== 16'd1 || err_valid_drop !== 3'b000) begin
      n_bad++; $display("FAIL data_change_xfer got cnt=%0d vd=%b exp 1/000", xfer_count[31:16], err_valid_drop);
    end
    pulse_clear();
    $display("test_data_change: done");
  endtask

  task automatic test_timeout();
    for (int i = 0; i < TO - 1; i++) begin
      drive(2, 1, 0, 4'h5); tick();
    end
    drive(2, 1, 1, 4'h5); tick();
    idle_all(); tick();
    n_vec++; if (err_timeout !== 3'b000 || any_error !== 1'b0) begin
      n_bad++; $display("FAIL timeout_short got to=%b any=%b exp 000/0", err_timeout, any_error);
    end
    for (int i = 0; i < TO - 1; i++) begin
      drive(2, 1, 0, 4'h6); tick();
    end
    n_vec++; if (err_timeout !== 3'b000) begin
      n_bad++; $display("FAIL timeout_early got %b exp 000", err_timeout);
    end
    tick();
    n_vec++; if (err_timeout !== 3'b100 || first_err_ch !== 3'd2 || any_error !== 1'b1) begin
      n_bad++; $display("FAIL timeout_hit got to=%b first=%b any=%b exp 100/010/1", err_timeout, first_err_ch, any_error);
    end
    for (int i = 0; i < 3; i++) tick();
    drive(2, 1, 1, 4'h6); tick();
    idle_all(); tick();
    n_vec++; if (err_timeout !== 3'b100 || xfer_count[47:32] !== 16'd2 || err_valid_drop !== 3'b000) begin
      n_bad++; $display("FAIL timeout_after got to=%b cnt=%0d vd=%b exp 100/2/000", err_timeout, xfer_count[47:32], err_valid_drop);
    end
    pulse_clear();
    $display("test_timeout: done");
  endtask

  task automatic test_valid_drop_clear();
    drive(0, 1, 0, 4'h3); drive(2, 1, 0, 4'hC);
    for (int i = 0; i < 3; i++) tick();
    idle_all(); tick();
    n_vec++; if (err_valid_drop !== 3'b101 || first_err_ch !== 3'd0 || any_error !== 1'b1) begin
      n_bad++; $display("FAIL valid_drop got vd=%b first=%b any=%b exp 101/000/1", err_valid_drop, first_err_ch, any_error);
    end
    pulse_clear();
    n_vec++; if ({err_valid_drop, err_data_change, err_timeout, any_error} !== 10'd0 || first_err_ch !== 3'b111 || xfer_count !== 48'd0) begin
      n_bad++; $display("FAIL clear got err=%b first=%b cnt=%h exp 0/111/0",
                        {err_valid_drop, err_data_change, err_timeout, any_error}, first_err_ch, xfer_count);
    end
    $display("test_valid_drop_clear: done");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 1, 4'($urandom)); tick();
    end
    idle_all(); tick();
    n_vec++; if (s_xfer[7:4] !== 4'd15) begin
      n_bad++; $display("FAIL sat_cnt4 got %0d exp 15", s_xfer[7:4]);
    end
    n_vec++; if (xfer_count[31:16] !== 16'd20) begin
      n_bad++; $display("FAIL sat_cnt16 got %0d exp 20", xfer_count[31:16]);
    end
    pulse_clear();
    $display("test_saturation: done");
  endtask

  task automatic test_reset_enable();
    drive(0, 1, 1, 4'h1); tick(); tick(); drive(0, 0, 0, 4'h1);
    for (int i = 0; i < 10; i++) begin
      drive(2, 1, 0, 4'h7); tick();
    end
    enable = 0;
    drive(2, 1, 0, 4'h8); tick();
    drive(2, 0, 0, 4'h8); tick();
    drive(2, 1, 1, 4'h9); tick();
    enable = 1;
    for (int i = 0; i < 10; i++) begin
      drive(2, 1, 0, 4'h9); tick();
    end
    drive(2, 1, 1, 4'h9); tick();
    idle_all(); tick();
    n_vec++; if (any_error !== 1'b0 || err_timeout !== 3'b000) begin
      n_bad++; $display("FAIL enable_gap got any=%b to=%b exp 0/000", any_error, err_timeout);
    end
    n_vec++; if (xfer_count[15:0] !== 16'd2 || xfer_count[47:32] !== 16'd1) begin
      n_bad++; $display("FAIL enable_hold got ch0=%0d ch2=%0d exp 2/1", xfer_count[15:0], xfer_count[47:32]);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 4'h4); tick();
    end
    RESET = 1; tick(); tick(); RESET = 0;
    n_vec++; if (xfer_count !== 48'd0 || any_error !== 1'b0 || first_err_ch !== 3'b111) begin
      n_bad++; $display("FAIL reset_stall got cnt=%h any=%b first=%b exp 0/0/111", xfer_count, any_error, first_err_ch);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 4'h4); tick();
    end
    drive(1, 1, 1, 4'h4); tick();
    idle_all(); tick();
    n_vec++; if (any_error !== 1'b0 || xfer_count !== 48'h0000_0001_0000) begin
      n_bad++; $display("FAIL reset_resume got any=%b cnt=%h exp 0/000000010000", any_error, xfer_count);
    end
    pulse_clear();
    $display("test_reset_enable: done");
  endtask

  task automatic test_random();
    logic [3:0] cur_d[NCH];
    int ready_pct;
    for (int c = 0; c < NCH; c++) cur_d[c] = 4'($urandom);
    for (int t = 0; t < 900; t++) begin
      ready_pct = (t / 100) % 3 == 0 ? 8 : ((t / 100) % 3 == 1 ? 50 : 90);
      RESET        = ($urandom_range(0, 299) == 0);
      clear_counts = ($urandom_range(0, 149) == 0);
      enable       = ($urandom_range(0, 39) != 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 99) < 8) cur_d[c] = 4'($urandom);
        drive(c, $urandom_range(0, 99) < 92, $urandom_range(0, 99) < ready_pct, cur_d[c]);
      end
      tick();
      n_vec++; if ({err_valid_drop, err_data_change, err_timeout} !== {m_vd, m_dc, m_to}) begin
        n_bad++; $display("FAIL rnd_err t=%0d got %b exp %b", t, {err_valid_drop, err_data_change, err_timeout}, {m_vd, m_dc, m_to});
      end
      n_vec++; if (any_error !== |{m_vd, m_dc, m_to}) begin
        n_bad++; $display("FAIL rnd_any t=%0d got %b exp %b", t, any_error, |{m_vd, m_dc, m_to});
      end
      n_vec++; if (first_err_ch !== (m_first < 0 ? 3'b111 : 3'(m_first))) begin
        n_bad++; $display("FAIL rnd_first t=%0d got %b exp %0d", t, first_err_ch, m_first);
      end
      n_vec++; if (xfer_count !== exp_xfer() || s_xfer !== exp_xfer4()) begin
        n_bad++; $display("FAIL rnd_cnt t=%0d got %h/%h exp %h/%h", t, xfer_count, s_xfer, exp_xfer(), exp_xfer4());
      end
    end
    RESET = 0; clear_counts = 0; enable = 1; idle_all();
    $display("test_random: 900 cycles, timeouts seen=%b", m_to);
  endtask

  initial begin
    RESET = 1; enable = 1; clear_counts = 0;
    ch_valid = 0; ch_ready = 0; ch_data = 0;
    model_clear();
    test_reset();
    test_transfers();
    test_data_change();
    test_timeout();
    test_valid_drop_clear();
    test_saturation();
    test_reset_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
